onchip_mem_port_arbiter: RTL and testbench
==========================================

Name: onchip_mem_port_arbiter

Overview:
- Shares one 32-bit port of the 2024-word dual-port on-chip RAM between two Avalon-MM masters.
  - Master 0: Nios data master.
  - Master 1: TCP packet DMA.
- Performs weighted round-robin arbitration.
- Registers the winning command onto the RAM port and returns read data with fixed latency via readdatavalid.
- Sits between the interconnect and RAM port s1. Port s2 stays dedicated to the MAC path.

Parameters:
- ADDR_W, 11: word-address width of masters and RAM.
- DEPTH, 2024: number of implemented words. Addresses >= DEPTH are out of range.
- HOLD, 4: max consecutive grants to one master while the other is waiting, 1..15.

Ports:
- clk  in  1  single clock, shared with the RAM.
- reset_n  in  1  asynchronous, active-low reset.
- m0_address  in  ADDR_W  word address.
- m0_read  in  1  read request.
- m0_write  in  1  write request.
- m0_byteenable  in  4  byte enables.
- m0_writedata  in  32  write data.
- m0_waitrequest  out  1  high = command not accepted this cycle.
- m0_readdata  out  32  read data.
- m0_readdatavalid  out  1  read data valid.
- m1_*: same seven signals as m0_*, for master 1.
- mem_address  out  ADDR_W  registered RAM address.
- mem_chipselect  out  1  registered RAM select.
- mem_write  out  1  registered RAM write.
- mem_byteenable  out  4  registered RAM byte enables.
- mem_writedata  out  32  registered RAM write data.
- mem_clken  out  1  tied high.
- mem_readdata  in  32  RAM q. Unregistered output, address registered inside the RAM.
- oor_error  out  1  sticky: an out-of-range access was seen.
- oor_clear  in  1  clears oor_error.

Behaviour:
- Reset values (reset_n low): all mem_* registers 0, mX_readdatavalid 0, mX_readdata 0, oor_error 0, last_grant = 1, run_cnt = 0, read pipeline cleared.
- mX_waitrequest is combinational and is 1 while reset_n is low.
- Request: master X requests when mX_read | mX_write. Asserting both read and write in one cycle is illegal; treat it as a write.
- Grant (combinational, each cycle):
  - One requester: it wins.
  - Both requesting, and last_grant holds with run_cnt < HOLD: last_grant wins.
  - Both requesting otherwise: the other master wins.
- Winner gets mX_waitrequest = 0. The loser, and any idle master, sees waitrequest = 1. Accept = request & ~waitrequest.
- State update on accept:
  - Same master as last_grant: run_cnt increments, saturating at 15.
  - Other master: last_grant = winner, run_cnt = 1.
  - No accept: run_cnt = 0, last_grant unchanged.
- Command stage (T+1), cycle after accept at T: mem_address, mem_byteenable and mem_writedata take the winner's values.
  - mem_chipselect = 1 only if the address is < DEPTH.
  - mem_write = write & in-range.
  - No accept: mem_chipselect = 0, mem_write = 0; address and data hold.
- Read pipeline: 2-deep tag shift register carrying {valid, master id, oor}.
  - A read accepted at T gives mX_readdatavalid = 1 at T+2 for the owning master only.
  - mX_readdata = mem_readdata, or 0 if the read was out of range.
  - Fixed read latency 2, fully pipelined: one read per cycle, in order.
  - Writes produce no response and complete at T+1.
- Out of range (address >= DEPTH):
  - The command is still accepted. Writes are dropped; reads return 0.
  - oor_error is set at T+1.
  - oor_clear in the same cycle as a new oor event: set wins.
- Back-to-back mixed traffic: a write at T and a read at T+1 to the same address return the new data. The RAM ports are decided for this case.
- Reset mid-operation: in-flight reads are discarded, with no readdatavalid after reset release. The first grant after reset favours m0, because last_grant = 1 and m1 was "last".
- Cross-port hazards with the s2 user are not handled here.

Test Plan:
1. Reset release, m0 reads addr 0x005 (RAM holds 0xA5A5_0005) -> m0_waitrequest=0 at T, mem_address=0x005 and mem_chipselect=1 at T+1, m0_readdatavalid=1 and m0_readdata=0xA5A5_0005 at T+2; m1_readdatavalid stays 0.
2. Both masters continuously write with HOLD=4 -> grant pattern m0,m0,m0,m0,m1,m1,m1,m1,m0…; no starvation; mem_write asserted every cycle.
3. m1 write 0x1234_5678 to addr 0x100 with byteenable=4'b0011, then m1 read of 0x100 the next cycle -> read returns old upper 16 bits and 0x5678 in the lower 16 bits at T+2 of the read.
4. m0 writes addr 2030, then m0 reads addr 2030 -> mem_chipselect=0 and mem_write=0 for the write; the read returns 0 with readdatavalid=1; oor_error=1 until oor_clear pulses; clear and event in the same cycle leave oor_error=1.
5. Interleaved reads m0@10, m1@20, m0@30 on consecutive cycles -> readdatavalid pulses at T+2, T+3, T+4 routed to m0, m1, m0 with matching data.
6. reset_n asserted low 1 cycle after a read is accepted -> no readdatavalid appears; all outputs return to reset values; normal operation after release.

Source files
------------

// File: rtl/onchip_mem_port_arbiter.sv
// onchip_mem_port_arbiter: weighted round-robin share of one RAM port
// between two Avalon-MM masters, reads returned two cycles after accept.
module onchip_mem_port_arbiter #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DEPTH  = 2024,
    parameter int unsigned HOLD   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [3:0]        m0_byteenable,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [3:0]        m1_byteenable,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic              oor_error,
    input  logic              oor_clear
);

    localparam logic [3:0] HOLD_C = 4'(HOLD);

    logic              req0;
    logic              req1;
    logic              gnt0;
    logic              gnt1;
    logic              acc;
    logic              win;

    logic              last_q;
    logic              last_d;
    logic [3:0]        run_q;
    logic [3:0]        run_d;

    logic [ADDR_W-1:0] sel_addr;
    logic              sel_wr;
    logic [3:0]        sel_be;
    logic [31:0]       sel_wd;
    logic              sel_inr;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              cs_q;
    logic              cs_d;
    logic              wr_q;
    logic              wr_d;
    logic [3:0]        be_q;
    logic [3:0]        be_d;
    logic [31:0]       wd_q;
    logic [31:0]       wd_d;
    logic              oor_q;
    logic              oor_d;

    // read tags: {valid, master id, out-of-range}
    logic [2:0]        tag1_q;
    logic [2:0]        tag1_d;
    logic [2:0]        tag2_q;
    logic              rsp_v;
    logic              rsp_id;
    logic              rsp_oor;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // an active run of the last winner continues below HOLD, else alternate
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (run_q != 4'd0 && run_q < HOLD_C) begin
                gnt0 = ~last_q;
                gnt1 = last_q;
            end else begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
        if (!reset_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;
    assign acc            = gnt0 | gnt1;
    assign win            = gnt1;

    always_comb begin
        sel_addr = win ? m1_address    : m0_address;
        sel_wr   = win ? m1_write      : m0_write;
        sel_be   = win ? m1_byteenable : m0_byteenable;
        sel_wd   = win ? m1_writedata  : m0_writedata;
        sel_inr  = 32'(sel_addr) < DEPTH;
    end

    always_comb begin
        last_d = last_q;
        run_d  = 4'd0;
        if (acc) begin
            if (win == last_q) begin
                run_d = (run_q == 4'd15) ? run_q : run_q + 4'd1;
            end else begin
                last_d = win;
                run_d  = 4'd1;
            end
        end
    end

    always_comb begin
        addr_d = addr_q;
        be_d   = be_q;
        wd_d   = wd_q;
        cs_d   = 1'b0;
        wr_d   = 1'b0;
        if (acc) begin
            addr_d = sel_addr;
            be_d   = sel_be;
            wd_d   = sel_wd;
            cs_d   = sel_inr;
            wr_d   = sel_wr & sel_inr;
        end
    end

    // a new event beats a simultaneous clear
    assign oor_d  = (acc & ~sel_inr) | (oor_q & ~oor_clear);
    assign tag1_d = {acc & ~sel_wr, win, ~sel_inr};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
            run_q  <= 4'd0;
            addr_q <= '0;
            cs_q   <= 1'b0;
            wr_q   <= 1'b0;
            be_q   <= 4'd0;
            wd_q   <= 32'd0;
            oor_q  <= 1'b0;
            tag1_q <= 3'd0;
            tag2_q <= 3'd0;
        end else begin
            last_q <= last_d;
            run_q  <= run_d;
            addr_q <= addr_d;
            cs_q   <= cs_d;
            wr_q   <= wr_d;
            be_q   <= be_d;
            wd_q   <= wd_d;
            oor_q  <= oor_d;
            tag1_q <= tag1_d;
            tag2_q <= tag1_q;
        end
    end

    assign mem_address    = addr_q;
    assign mem_chipselect = cs_q;
    assign mem_write      = wr_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = wd_q;
    assign mem_clken      = 1'b1;
    assign oor_error      = oor_q;

    assign rsp_v   = tag2_q[2];
    assign rsp_id  = tag2_q[1];
    assign rsp_oor = tag2_q[0];

    // RAM q is unregistered here, so data lines up with the second tag stage
    always_comb begin
        m0_readdatavalid = rsp_v & ~rsp_id;
        m1_readdatavalid = rsp_v & rsp_id;
        m0_readdata      = 32'd0;
        m1_readdata      = 32'd0;
        if (m0_readdatavalid && !rsp_oor) begin
            m0_readdata = mem_readdata;
        end
        if (m1_readdatavalid && !rsp_oor) begin
            m1_readdata = mem_readdata;
        end
    end

endmodule

// File: tb/tb_onchip_mem_port_arbiter.sv
// tb_onchip_mem_port_arbiter: directed traffic against a RAM model with a
// read-response scoreboard and a reference arbitration model.
module tb_onchip_mem_port_arbiter;

    localparam int AW    = 11;
    localparam int DEPTH = 2024;
    localparam int HOLD  = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] m0_address = '0;
    logic          m0_read = 1'b0;
    logic          m0_write = 1'b0;
    logic [3:0]    m0_byteenable = 4'hF;
    logic [31:0]   m0_writedata = '0;
    logic          m0_waitrequest;
    logic [31:0]   m0_readdata;
    logic          m0_readdatavalid;
    logic [AW-1:0] m1_address = '0;
    logic          m1_read = 1'b0;
    logic          m1_write = 1'b0;
    logic [3:0]    m1_byteenable = 4'hF;
    logic [31:0]   m1_writedata = '0;
    logic          m1_waitrequest;
    logic [31:0]   m1_readdata;
    logic          m1_readdatavalid;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect;
    logic          mem_write;
    logic [3:0]    mem_byteenable;
    logic [31:0]   mem_writedata;
    logic          mem_clken;
    logic [31:0]   mem_readdata;
    logic          oor_error;
    logic          oor_clear = 1'b0;

    always #5 clk = ~clk;

    onchip_mem_port_arbiter #(
        .ADDR_W(AW),
        .DEPTH(DEPTH),
        .HOLD(HOLD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .m0_address(m0_address),
        .m0_read(m0_read),
        .m0_write(m0_write),
        .m0_byteenable(m0_byteenable),
        .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address),
        .m1_read(m1_read),
        .m1_write(m1_write),
        .m1_byteenable(m1_byteenable),
        .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address),
        .mem_chipselect(mem_chipselect),
        .mem_write(mem_write),
        .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata),
        .mem_clken(mem_clken),
        .mem_readdata(mem_readdata),
        .oor_error(oor_error),
        .oor_clear(oor_clear)
    );

    // RAM: registered address, unregistered q, write visible to later reads
    logic [31:0]   ram [0:2047];
    logic [AW-1:0] ram_aq = '0;

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 32'hA5A5_0000 | 32'(i);
    end

    always @(posedge clk) begin
        if (mem_clken) begin
            if (mem_chipselect && mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b])
                        ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end
            ram_aq <= mem_address;
        end
    end

    assign mem_readdata = ram[ram_aq];

    typedef struct {
        int          due;
        logic        m;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] shadow [0:2047];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          win_log = -1;
    logic        last_m;
    int          run_m;
    logic [AW-1:0] e_addr;
    logic        e_cs;
    logic        e_wr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        e_oor;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last_m = 1'b1;
        run_m  = 0;
        e_addr = '0;
        e_cs   = 1'b0;
        e_wr   = 1'b0;
        e_be   = 4'd0;
        e_wd   = 32'd0;
        e_oor  = 1'b0;
        sb.delete();
    endtask

    task automatic idle();
        m0_read  = 1'b0;
        m0_write = 1'b0;
        m1_read  = 1'b0;
        m1_write = 1'b0;
    endtask

    task automatic drv(input int m, input bit rd, input bit wr,
                       input logic [AW-1:0] a, input logic [3:0] be,
                       input logic [31:0] wd);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a;
            m0_byteenable = be; m0_writedata = wd;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a;
            m1_byteenable = be; m1_writedata = wd;
        end
    endtask

    // one clock: check at the falling edge, then step the model
    task automatic tick();
        bit          r0, r1, acc, w, wr, inr, ev, v;
        logic [AW-1:0] a;
        logic [3:0]  be;
        logic [31:0] wd, d;
        @(negedge clk);
        cyc++;
        if (!reset_n) model_reset();
        chk("mem_address", 32'(mem_address), 32'(e_addr));
        chk("mem_chipselect", 32'(mem_chipselect), 32'(e_cs));
        chk("mem_write", 32'(mem_write), 32'(e_wr));
        chk("mem_byteenable", 32'(mem_byteenable), 32'(e_be));
        chk("mem_writedata", mem_writedata, e_wd);
        chk("mem_clken", 32'(mem_clken), 32'd1);
        chk("oor_error", 32'(oor_error), 32'(e_oor));
        for (int m = 0; m < 2; m++) begin
            ev = sb.size() > 0 && sb[0].due == cyc && sb[0].m == m[0];
            v  = (m == 0) ? m0_readdatavalid : m1_readdatavalid;
            d  = (m == 0) ? m0_readdata : m1_readdata;
            chk(m == 0 ? "m0_readdatavalid" : "m1_readdatavalid",
                32'(v), 32'(ev));
            if (ev) begin
                chk(m == 0 ? "m0_readdata" : "m1_readdata", d, sb[0].data);
                void'(sb.pop_front());
            end
        end
        r0  = reset_n && (m0_read || m0_write);
        r1  = reset_n && (m1_read || m1_write);
        acc = r0 || r1;
        if (r0 && r1) w = (run_m != 0 && run_m < HOLD) ? last_m : !last_m;
        else          w = r1;
        chk("m0_waitrequest", 32'(m0_waitrequest), 32'(!(acc && !w)));
        chk("m1_waitrequest", 32'(m1_waitrequest), 32'(!(acc && w)));
        win_log = acc ? int'(w) : -1;
        if (reset_n) begin
            inr = 1'b1;
            if (acc) begin
                if (w == last_m) run_m = (run_m == 15) ? 15 : run_m + 1;
                else begin
                    last_m = w;
                    run_m  = 1;
                end
                a   = w ? m1_address : m0_address;
                wr  = w ? m1_write : m0_write;
                be  = w ? m1_byteenable : m0_byteenable;
                wd  = w ? m1_writedata : m0_writedata;
                inr = int'(a) < DEPTH;
                e_addr = a; e_be = be; e_wd = wd;
                e_cs = inr;
                e_wr = wr && inr;
                if (wr && inr) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) shadow[a][8*b +: 8] = wd[8*b +: 8];
                end
                if (!wr) sb.push_back('{cyc + 2, w, inr ? shadow[a] : 32'd0});
            end else begin
                run_m = 0;
                e_cs  = 1'b0;
                e_wr  = 1'b0;
            end
            e_oor = (acc && !inr) ? 1'b1 : (oor_clear ? 1'b0 : e_oor);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pat[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 2048; i++) shadow[i] = 32'hA5A5_0000 | 32'(i);
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // single read by m0
        drv(0, 1, 0, 11'h005, 4'hF, 32'd0);
        tick();
        idle();
        repeat (3) tick();

        // contention: m0 starts a run, m1 joins
        drv(0, 0, 1, 11'h200, 4'hF, 32'hD0D0_0000);
        for (int i = 0; i < 12; i++) begin
            if (i == 1) drv(1, 0, 1, 11'h300, 4'hF, 32'hE1E1_0000);
            tick();
            chk("grant_pattern", 32'(win_log), 32'(pat[i]));
        end
        idle();
        tick();

        // partial write then read-back by m1
        drv(1, 0, 1, 11'h100, 4'b0011, 32'h1234_5678);
        tick();
        drv(1, 1, 0, 11'h100, 4'hF, 32'd0);
        tick();
        idle();
        repeat (3) tick();

        // out-of-range write and read, clear, clear racing a new event
        drv(0, 0, 1, 11'd2030, 4'hF, 32'hDEAD_BEEF);
        tick();
        drv(0, 1, 0, 11'd2030, 4'hF, 32'd0);
        tick();
        idle();
        repeat (3) tick();
        oor_clear = 1'b1;
        tick();
        oor_clear = 1'b0;
        tick();
        drv(0, 1, 0, 11'd2047, 4'hF, 32'd0);
        oor_clear = 1'b1;
        tick();
        oor_clear = 1'b0;
        idle();
        repeat (3) tick();
        oor_clear = 1'b1;
        tick();
        oor_clear = 1'b0;

        // interleaved reads
        drv(0, 1, 0, 11'd10, 4'hF, 32'd0);
        tick();
        idle();
        drv(1, 1, 0, 11'd20, 4'hF, 32'd0);
        tick();
        idle();
        drv(0, 1, 0, 11'd30, 4'hF, 32'd0);
        tick();
        idle();
        repeat (4) tick();

        // reset one cycle after a read is accepted
        drv(0, 1, 0, 11'd40, 4'hF, 32'd0);
        tick();
        idle();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        drv(0, 1, 0, 11'd50, 4'hF, 32'd0);
        drv(1, 1, 0, 11'd60, 4'hF, 32'd0);
        tick();
        chk("first_grant_after_reset", 32'(win_log), 32'd0);
        idle();
        drv(1, 1, 0, 11'd60, 4'hF, 32'd0);
        tick();
        idle();
        repeat (4) tick();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
